// File: rtl/memory_arbiter_pkg.sv
// Shared types, state encodings and the tie-break helper for the memory bus arbiter.
package memory_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [0:0] {
    arb_idle = 1'b0,
    arb_busy = 1'b1
  } arb_state_type;

  localparam logic arb_fetch = 1'b0;
  localparam logic arb_data  = 1'b1;

  // Pending slots live in memory_arbiter_slot; req holds the granted request while BUSY.
  typedef struct packed {
    arb_state_type state;
    logic          owner;
    logic          last;
    mem_in_type    req;
  } memory_arbiter_reg_type;

  localparam memory_arbiter_reg_type init_memory_arbiter_reg = '{
    state: arb_idle,
    owner: arb_fetch,
    last:  arb_fetch,
    req:   '0
  };

  function automatic logic pick_winner(input logic cand_i, input logic cand_d, input logic last);
    if (cand_i && cand_d) begin
      return ~last;
    end else if (cand_d) begin
      return arb_data;
    end else begin
      return arb_fetch;
    end
  endfunction

endpackage

// File: rtl/memory_arbiter_slot.sv
// Per-port pending-request register: captures an ungranted pulse, cleared on grant,
// and flags a second pulse arriving while it is already full.
module memory_arbiter_slot
  import memory_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_set,
  input  logic       i_clear,
  input  mem_in_type i_req,
  output mem_in_type o_slot,
  output logic       o_violation
);

  mem_in_type r_slot;

  assign o_slot      = r_slot;
  assign o_violation = i_set & r_slot.mem_valid;

  // Slot register; a set against a full slot is a duplicate and is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_slot <= '0;
    end else if (i_clear) begin
      r_slot <= '0;
    end else if (i_set && !r_slot.mem_valid) begin
      r_slot <= i_req;
    end else begin
      r_slot <= r_slot;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory bus between fetch and data ports with one transaction outstanding;
// ties alternate starting with data, completions are routed back to the owner.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out,
  output logic        o_protocol_violation
);

  memory_arbiter_reg_type r;
  memory_arbiter_reg_type rin;

  mem_in_type w_slot_i;
  mem_in_type w_slot_d;
  logic       w_set_i;
  logic       w_set_d;
  logic       w_clr_i;
  logic       w_clr_d;
  logic       w_sviol_i;
  logic       w_sviol_d;
  logic       w_acc_i;
  logic       w_acc_d;
  logic       w_cand_i;
  logic       w_cand_d;
  logic       w_win;
  logic       w_viol;
  logic       r_violation;

  memory_arbiter_slot u_slot_i (
    .clock       (clock),
    .reset       (reset),
    .i_set       (w_set_i),
    .i_clear     (w_clr_i),
    .i_req       (imem_in),
    .o_slot      (w_slot_i),
    .o_violation (w_sviol_i)
  );

  memory_arbiter_slot u_slot_d (
    .clock       (clock),
    .reset       (reset),
    .i_set       (w_set_d),
    .i_clear     (w_clr_d),
    .i_req       (dmem_in),
    .o_slot      (w_slot_d),
    .o_violation (w_sviol_d)
  );

  // Grant selection, slot control, bus drive and response routing.
  always_comb begin
    memory_arbiter_reg_type v;
    v = r;

    // A pulse from the port that currently owns the bus is illegal and never accepted.
    w_acc_i  = imem_in.mem_valid & ~((r.state == arb_busy) & (r.owner == arb_fetch));
    w_acc_d  = dmem_in.mem_valid & ~((r.state == arb_busy) & (r.owner == arb_data));
    w_cand_i = w_slot_i.mem_valid | w_acc_i;
    w_cand_d = w_slot_d.mem_valid | w_acc_d;
    w_win    = pick_winner(w_cand_i, w_cand_d, r.last);

    w_clr_i = 1'b0;
    w_clr_d = 1'b0;
    w_set_i = w_acc_i;
    w_set_d = w_acc_d;

    mem_in           = r.req;
    mem_in.mem_valid = 1'b0;

    imem_out.mem_ready = 1'b0;
    imem_out.mem_rdata = mem_out.mem_rdata;
    dmem_out.mem_ready = 1'b0;
    dmem_out.mem_rdata = mem_out.mem_rdata;

    case (r.state)
      arb_idle: begin
        if (w_cand_i || w_cand_d) begin
          // A parked request beats the same port's fresh pulse; that pulse is then a duplicate.
          if (w_win == arb_data) begin
            mem_in  = w_slot_d.mem_valid ? w_slot_d : dmem_in;
            w_clr_d = w_slot_d.mem_valid;
            w_set_d = w_acc_d & w_slot_d.mem_valid;
          end else begin
            mem_in  = w_slot_i.mem_valid ? w_slot_i : imem_in;
            w_clr_i = w_slot_i.mem_valid;
            w_set_i = w_acc_i & w_slot_i.mem_valid;
          end
          mem_in.mem_valid = 1'b1;
          v.req   = mem_in;
          v.owner = w_win;
          v.last  = w_win;
          v.state = arb_busy;
        end else begin
          v.state = arb_idle;
        end
      end
      arb_busy: begin
        if (mem_out.mem_ready) begin
          if (r.owner == arb_data) begin
            dmem_out.mem_ready = 1'b1;
          end else begin
            imem_out.mem_ready = 1'b1;
          end
          v.state = arb_idle;
        end else begin
          v.state = arb_busy;
        end
      end
      default: begin
        v = init_memory_arbiter_reg;
      end
    endcase

    rin = v;
  end

  assign w_viol = (imem_in.mem_valid & ~w_acc_i) | (dmem_in.mem_valid & ~w_acc_d)
                | w_sviol_i | w_sviol_d;

  assign o_protocol_violation = r_violation;

  // Arbiter state register and registered violation flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r           <= init_memory_arbiter_reg;
      r_violation <= 1'b0;
    end else begin
      r           <= rin;
      r_violation <= w_viol;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and random stimulus for memory_arbiter, checked every cycle against a
// request-level model of the arbitration rules.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type mem_out;
  logic        o_protocol_violation;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: parked requests per port (0 = fetch, 1 = data), bus owner, last winner.
  logic       m_pend [2];
  mem_in_type m_preq [2];
  logic       m_busy;
  int         m_own;
  int         m_lst;
  mem_in_type m_held;
  logic       m_viol_exp;

  memory_arbiter dut (
    .reset                (reset),
    .clock                (clock),
    .imem_in              (imem_in),
    .imem_out             (imem_out),
    .dmem_in              (dmem_in),
    .dmem_out             (dmem_out),
    .mem_in               (mem_in),
    .mem_out              (mem_out),
    .o_protocol_violation (o_protocol_violation)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0;
      m_preq[k] = '0;
    end
    m_busy     = 1'b0;
    m_own      = 0;
    m_lst      = 0;
    m_held     = '0;
    m_viol_exp = 1'b0;
  endtask

  task automatic drive_i(input logic [31:0] addr);
    imem_in = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: addr, mem_wdata: 32'h0, mem_wstrb: 4'h0};
  endtask

  task automatic drive_d(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    dmem_in = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: addr, mem_wdata: wdata, mem_wstrb: wstrb};
  endtask

  task automatic ready(input logic [31:0] rdata);
    mem_out = '{mem_ready: 1'b1, mem_rdata: rdata};
  endtask

  // Let combinational outputs settle, compare them with the model, advance the model.
  task automatic settle();
    mem_in_type  inr   [2];
    logic        legal [2];
    logic        cand  [2];
    logic        any_v;
    logic        was_busy;
    int          w;
    mem_in_type  e_in;
    mem_out_type e_i;
    mem_out_type e_d;
    #2;
    inr[0]   = imem_in;
    inr[1]   = dmem_in;
    any_v    = 1'b0;
    was_busy = m_busy;
    for (int k = 0; k < 2; k++) begin
      legal[k] = inr[k].mem_valid && !m_pend[k] && !(m_busy && m_own == k);
      if (inr[k].mem_valid && !legal[k]) any_v = 1'b1;
      cand[k] = m_pend[k] || legal[k];
    end
    e_in = m_held;
    e_in.mem_valid = 1'b0;
    e_i = '{mem_ready: 1'b0, mem_rdata: mem_out.mem_rdata};
    e_d = e_i;
    if (!was_busy && (cand[0] || cand[1])) begin
      if (cand[0] && cand[1]) w = 1 - m_lst;
      else if (cand[1]) w = 1;
      else w = 0;
      e_in = m_pend[w] ? m_preq[w] : inr[w];
      e_in.mem_valid = 1'b1;
      m_held = e_in;
      if (m_pend[w]) m_pend[w] = 1'b0;
      else legal[w] = 1'b0;
      m_busy = 1'b1;
      m_own  = w;
      m_lst  = w;
    end else if (was_busy && mem_out.mem_ready) begin
      if (m_own == 1) e_d.mem_ready = 1'b1;
      else e_i.mem_ready = 1'b1;
      m_busy = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (legal[k]) begin
        m_pend[k] = 1'b1;
        m_preq[k] = inr[k];
      end
    end
    chk("mem_in", 128'(mem_in), 128'(e_in));
    chk("imem_out", 128'(imem_out), 128'(e_i));
    chk("dmem_out", 128'(dmem_out), 128'(e_d));
    m_viol_exp = any_v;
    if (reset) model_reset();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    chk("violation", 128'(o_protocol_violation), 128'(m_viol_exp));
    @(negedge clock);
    imem_in.mem_valid = 1'b0;
    dmem_in.mem_valid = 1'b0;
    mem_out.mem_ready = 1'b0;
    mem_out.mem_rdata = $urandom();
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic do_reset();
    imem_in.mem_valid = 1'b0;
    dmem_in.mem_valid = 1'b0;
    mem_out.mem_ready = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_instr;
    int   nd;
    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    reset   = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("rst_mem_in", 128'(mem_in), 128'(0));
    chk("rst_iready", 128'(imem_out.mem_ready), 128'(0));
    chk("rst_dready", 128'(dmem_out.mem_ready), 128'(0));
    chk("rst_viol", 128'(o_protocol_violation), 128'(0));
    @(negedge clock);

    // Lone data load, reply three cycles after the grant.
    drive_d(32'h100, 32'h0, 4'h0);
    settle();
    chk("t1_valid", 128'(mem_in.mem_valid), 128'(1));
    chk("t1_addr", 128'(mem_in.mem_addr), 128'(32'h100));
    chk("t1_instr", 128'(mem_in.mem_instr), 128'(0));
    tick();
    cycle();
    cycle();
    ready(32'hDEADBEEF);
    settle();
    chk("t1_dready", 128'(dmem_out.mem_ready), 128'(1));
    chk("t1_rdata", 128'(dmem_out.mem_rdata), 128'(32'hDEADBEEF));
    chk("t1_iready", 128'(imem_out.mem_ready), 128'(0));
    tick();
    cycle();

    // Simultaneous pulses right after reset: data first, fetch one cycle after completion.
    do_reset();
    drive_i(32'h0);
    drive_d(32'h200, 32'h0, 4'h0);
    settle();
    chk("t2_first_instr", 128'(mem_in.mem_instr), 128'(0));
    chk("t2_first_addr", 128'(mem_in.mem_addr), 128'(32'h200));
    tick();
    cycle();
    ready(32'h1234_5678);
    cycle();
    settle();
    chk("t2_second_valid", 128'(mem_in.mem_valid), 128'(1));
    chk("t2_second_instr", 128'(mem_in.mem_instr), 128'(1));
    chk("t2_second_addr", 128'(mem_in.mem_addr), 128'(32'h0));
    tick();
    ready(32'h0BAD_F00D);
    cycle();
    cycle();

    // Both ports re-request after each completion: grants alternate D, I, D, I.
    do_reset();
    drive_i(32'h1000);
    drive_d(32'h2000, 32'h0, 4'h0);
    exp_instr = 1'b0;
    for (int g = 0; g < 8; g++) begin
      settle();
      chk("t3_grant", 128'(mem_in.mem_valid), 128'(1));
      chk("t3_owner", 128'(mem_in.mem_instr), 128'(exp_instr));
      tick();
      ready($urandom());
      cycle();
      if (exp_instr) drive_i(32'h1000 + 32'(g));
      else drive_d(32'h2000 + 32'(g), 32'h0, 4'h0);
      exp_instr = ~exp_instr;
    end

    // Fetch pulse in the data completion cycle is parked and granted the next cycle.
    do_reset();
    drive_d(32'h300, 32'h0, 4'h0);
    cycle();
    ready(32'h5555_AAAA);
    drive_i(32'h40);
    settle();
    chk("t4_no_grant", 128'(mem_in.mem_valid), 128'(0));
    tick();
    settle();
    chk("t4_grant", 128'(mem_in.mem_valid), 128'(1));
    chk("t4_instr", 128'(mem_in.mem_instr), 128'(1));
    tick();
    ready(32'h0);
    cycle();

    // Reset one cycle after a data grant; the late reply is ignored.
    do_reset();
    drive_d(32'h300, 32'h0, 4'h0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    settle();
    chk("t5_mem_in", 128'(mem_in), 128'(0));
    tick();
    ready(32'hCAFE_0001);
    settle();
    chk("t5_dready", 128'(dmem_out.mem_ready), 128'(0));
    chk("t5_iready", 128'(imem_out.mem_ready), 128'(0));
    tick();
    drive_d(32'h304, 32'h0, 4'h0);
    settle();
    chk("t5_regrant", 128'(mem_in.mem_valid), 128'(1));
    chk("t5_addr", 128'(mem_in.mem_addr), 128'(32'h304));
    tick();
    ready(32'h0);
    cycle();

    // Duplicate data pulse while parked: dropped, flagged, one data transaction only.
    do_reset();
    drive_i(32'h400);
    cycle();
    drive_d(32'h500, 32'h11, 4'h1);
    cycle();
    drive_d(32'h504, 32'h22, 4'h2);
    settle();
    tick();
    chk("t6_flag", 128'(o_protocol_violation), 128'(1));
    ready(32'h0);
    cycle();
    nd = 0;
    for (int j = 0; j < 6; j++) begin
      if (j == 2) ready(32'h0);
      settle();
      if (mem_in.mem_valid && !mem_in.mem_instr) begin
        nd++;
        chk("t6_addr", 128'(mem_in.mem_addr), 128'(32'h500));
      end
      tick();
    end
    chk("t6_data_grants", 128'(nd), 128'(1));

    // Random legal traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!m_pend[0] && !(m_busy && m_own == 0) && ($urandom() % 4 == 0))
        drive_i($urandom());
      if (!m_pend[1] && !(m_busy && m_own == 1) && ($urandom() % 4 == 0))
        drive_d($urandom(), $urandom(), 4'($urandom()));
      if (m_busy && ($urandom() % 3 == 0))
        ready($urandom());
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
